// File: rtl/mem_stage.sv
// Load/store stage: steers bytes onto a req/gnt/rvalid data port and registers one writeback result
// per instruction. Latency 1 (ALU/error), >=2 (store), >=3 (load); ready_o stalls EX while busy.
module mem_stage #(
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [WORD_WIDTH-1:0] ex_data_i,
   input  logic [WORD_WIDTH-1:0] rdata2_store_i,
   input  logic                  mem_read_i,
   input  logic                  mem_write_i,
   input  logic [1:0]            mem_size_i,
   input  logic                  mem_unsigned_i,
   input  logic [4:0]            rd_addr_i,
   input  logic                  reg_write_i,
   output logic                  data_req_o,
   input  logic                  data_gnt_i,
   output logic [WORD_WIDTH-1:0] data_addr_o,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [WORD_WIDTH-1:0] data_wdata_o,
   input  logic                  data_rvalid_i,
   input  logic [WORD_WIDTH-1:0] data_rdata_i,
   output logic                  wb_valid_o,
   output logic [WORD_WIDTH-1:0] wb_data_o,
   output logic [4:0]            wb_rd_o,
   output logic                  wb_we_o,
   output logic                  wb_err_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

   state_t                state;
   logic [1:0]            off_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [4:0]            rd_q;
   logic                  regw_q;
   logic                  is_mem;
   logic                  misal;
   logic [3:0]            be_n;
   logic [WORD_WIDTH-1:0] wdata_n;
   logic [WORD_WIDTH-1:0] shifted;
   logic [WORD_WIDTH-1:0] ld_val;

   assign ready_o = (state == IDLE);

   always_comb begin
      is_mem  = mem_read_i | mem_write_i;
      misal   = 1'b0;
      be_n    = 4'b1111;
      wdata_n = rdata2_store_i;
      case (mem_size_i)
         2'b00: begin
            be_n    = 4'b0001 << ex_data_i[1:0];
            wdata_n = {4{rdata2_store_i[7:0]}};
         end
         2'b01: begin
            misal   = ex_data_i[0];
            be_n    = 4'b0011 << ex_data_i[1:0];
            wdata_n = {2{rdata2_store_i[15:0]}};
         end
         2'b10:   misal = |ex_data_i[1:0];
         default: misal = 1'b1;
      endcase
   end

   // Move the addressed lane down to bit 0, then extend to full width.
   always_comb begin
      shifted = data_rdata_i >> {off_q, 3'b000};
      case (size_q)
         2'b00:   ld_val = uns_q ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   ld_val = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: ld_val = shifted;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         off_q        <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         rd_q         <= '0;
         regw_q       <= 1'b0;
         data_req_o   <= 1'b0;
         data_addr_o  <= '0;
         data_we_o    <= 1'b0;
         data_be_o    <= '0;
         data_wdata_o <= '0;
         wb_valid_o   <= 1'b0;
         wb_data_o    <= '0;
         wb_rd_o      <= '0;
         wb_we_o      <= 1'b0;
         wb_err_o     <= 1'b0;
      end else begin
         wb_valid_o <= 1'b0;
         case (state)
            IDLE: if (valid_i) begin
               off_q  <= ex_data_i[1:0];
               size_q <= mem_size_i;
               uns_q  <= mem_unsigned_i;
               rd_q   <= rd_addr_i;
               regw_q <= reg_write_i;
               if (!is_mem) begin
                  wb_valid_o <= 1'b1;
                  wb_data_o  <= ex_data_i;
                  wb_rd_o    <= rd_addr_i;
                  wb_we_o    <= reg_write_i;
                  wb_err_o   <= 1'b0;
               end else if (misal) begin
                  wb_valid_o <= 1'b1;
                  wb_data_o  <= ex_data_i;
                  wb_rd_o    <= rd_addr_i;
                  wb_we_o    <= 1'b0;
                  wb_err_o   <= 1'b1;
               end else begin
                  // read+write together is handled as a load
                  state        <= REQ;
                  data_req_o   <= 1'b1;
                  data_addr_o  <= {ex_data_i[WORD_WIDTH-1:2], 2'b00};
                  data_we_o    <= ~mem_read_i;
                  data_be_o    <= be_n;
                  data_wdata_o <= wdata_n;
               end
            end
            REQ: if (data_gnt_i) begin
               data_req_o <= 1'b0;
               if (data_we_o) begin
                  state      <= IDLE;
                  wb_valid_o <= 1'b1;
                  wb_rd_o    <= rd_q;
                  wb_we_o    <= 1'b0;
                  wb_err_o   <= 1'b0;
               end else begin
                  state <= WAIT_R;
               end
            end
            WAIT_R: if (data_rvalid_i) begin
               state      <= IDLE;
               wb_valid_o <= 1'b1;
               wb_data_o  <= ld_val;
               wb_rd_o    <= rd_q;
               wb_we_o    <= regw_q;
               wb_err_o   <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scenario bench for mem_stage: expected writebacks are queued at issue and popped at each wb pulse.
module tb_mem_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        valid_i;
   logic        ready_o;
   logic [31:0] ex_data_i;
   logic [31:0] rdata2_store_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [1:0]  mem_size_i;
   logic        mem_unsigned_i;
   logic [4:0]  rd_addr_i;
   logic        reg_write_i;
   logic        data_req_o;
   logic        data_gnt_i;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;
   logic        wb_valid_o;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_rd_o;
   logic        wb_we_o;
   logic        wb_err_o;

   mem_stage #(.WORD_WIDTH(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .ex_data_i(ex_data_i), .rdata2_store_i(rdata2_store_i),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_size_i(mem_size_i),
      .mem_unsigned_i(mem_unsigned_i), .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
      .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
      .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
      .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o),
      .wb_we_o(wb_we_o), .wb_err_o(wb_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        we;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic [31:0] ex, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic regw, input logic rd_op, input logic wr_op,
                        input logic [1:0] size, input logic uns);
      ex_data_i      = ex;
      rdata2_store_i = rs2;
      rd_addr_i      = rd;
      reg_write_i    = regw;
      mem_read_i     = rd_op;
      mem_write_i    = wr_op;
      mem_size_i     = size;
      mem_unsigned_i = uns;
      valid_i        = 1'b1;
      step();
      valid_i     = 1'b0;
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
   endtask

   task automatic serve(input int gnt_dly, input bit load, input int rv_dly,
                        input logic [31:0] rdata, output int req_cyc, output bit to);
      int n = 0;
      req_cyc = 0;
      to      = 1'b0;
      while (!data_req_o) begin
         if (n >= 20) begin to = 1'b1; return; end
         step();
         n++;
      end
      repeat (gnt_dly) begin
         if (data_req_o) req_cyc++;
         step();
      end
      if (data_req_o) req_cyc++;
      data_gnt_i = 1'b1;
      step();
      data_gnt_i = 1'b0;
      if (load) begin
         repeat (rv_dly - 1) step();
         data_rvalid_i = 1'b1;
         data_rdata_i  = rdata;
         step();
         data_rvalid_i = 1'b0;
      end
   endtask

   task automatic wait_wb(output bit to);
      int n = 0;
      to = 1'b0;
      while (!wb_valid_o) begin
         if (n >= 20) begin to = 1'b1; return; end
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      logic [110:0] got;
      rst_i = 1'b1;
      step();
      step();
      got = {ready_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
             wb_valid_o, wb_data_o, wb_rd_o, wb_we_o, wb_err_o};
      total++;
      if (got !== {1'b1, 110'b0}) begin
         bad++;
         $display("FAIL reset_state: got %h required %h", got, {1'b1, 110'b0});
      end
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_alu();
      exp_t e;
      exp_q.push_back('{32'h1234_5678, 5'd5, 1'b1, 1'b0});
      issue(32'h1234_5678, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
      total++;
      if (wb_valid_o !== 1'b1) begin
         bad++;
         $display("FAIL alu_latency: wb_valid=%b required 1", wb_valid_o);
      end
      e = exp_q.pop_front();
      total++;
      if ({wb_data_o, wb_rd_o, wb_we_o, wb_err_o} !== e) begin
         bad++;
         $display("FAIL alu_wb: got %h required %h", {wb_data_o, wb_rd_o, wb_we_o, wb_err_o}, e);
      end
      step();
      total++;
      if (wb_valid_o !== 1'b0 || wb_data_o !== 32'h1234_5678) begin
         bad++;
         $display("FAIL alu_pulse_hold: wb_valid=%b data=%h required 0/12345678", wb_valid_o, wb_data_o);
      end
   endtask

   task automatic test_store_byte();
      exp_t e;
      exp_q.push_back('{32'h0, 5'd9, 1'b0, 1'b0});
      issue(32'h0000_0103, 32'hAABB_CCDD, 5'd9, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, ready_o} !==
             {1'b1, 1'b1, 4'b1000, 32'h100, 32'hDDDD_DDDD, 1'b0}) begin
            bad++;
            $display("FAIL sb_req_hold[%0d]: req=%b we=%b be=%b addr=%h wdata=%h ready=%b required 1/1/1000/100/dddddddd/0",
                     i, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, ready_o);
         end
         if (i == 3) data_gnt_i = 1'b1;
         step();
      end
      data_gnt_i = 1'b0;
      total++;
      if ({data_req_o, ready_o, wb_valid_o} !== 3'b011) begin
         bad++;
         $display("FAIL sb_done: req=%b ready=%b wb_valid=%b required 0/1/1", data_req_o, ready_o, wb_valid_o);
      end
      e = exp_q.pop_front();
      total++;
      if ({wb_rd_o, wb_we_o, wb_err_o} !== {e.rd, e.we, e.err}) begin
         bad++;
         $display("FAIL sb_wb: rd/we/err got %h required %h", {wb_rd_o, wb_we_o, wb_err_o}, {e.rd, e.we, e.err});
      end
      step();
   endtask

   task automatic test_store_half();
      exp_t e;
      int   rc;
      bit   to;
      bit   wto;
      exp_q.push_back('{32'h0, 5'd10, 1'b0, 1'b0});
      issue(32'h0000_0102, 32'h1234_ABCD, 5'd10, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
      total++;
      if ({data_be_o, data_wdata_o, data_addr_o} !== {4'b1100, 32'hABCD_ABCD, 32'h100}) begin
         bad++;
         $display("FAIL sh_lanes: be=%b wdata=%h addr=%h required 1100/abcdabcd/100", data_be_o, data_wdata_o, data_addr_o);
      end
      serve(1, 1'b0, 0, 32'h0, rc, to);
      wait_wb(wto);
      e = exp_q.pop_front();
      total++;
      if (to || wto || rc != 2 || {wb_rd_o, wb_we_o, wb_err_o} !== {e.rd, e.we, e.err}) begin
         bad++;
         $display("FAIL sh_wb: req_cycles=%0d (required 2) timeout=%0d/%0d rd/we/err=%h required %h",
                  rc, to, wto, {wb_rd_o, wb_we_o, wb_err_o}, {e.rd, e.we, e.err});
      end
      step();
   endtask

   task automatic test_load_byte();
      exp_t e;
      int   rc;
      bit   to;
      bit   wto;
      for (int u = 0; u < 2; u++) begin
         exp_q.push_back('{(u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080, 5'd7, 1'b1, 1'b0});
         issue(32'h0000_0202, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b00, u[0]);
         total++;
         if ({data_req_o, data_we_o, data_be_o, data_addr_o} !== {1'b1, 1'b0, 4'b0100, 32'h200}) begin
            bad++;
            $display("FAIL lb_req[%0d]: req=%b we=%b be=%b addr=%h required 1/0/0100/200",
                     u, data_req_o, data_we_o, data_be_o, data_addr_o);
         end
         serve(0, 1'b1, 2, 32'h0080_0000, rc, to);
         wait_wb(wto);
         e = exp_q.pop_front();
         total++;
         if (to || wto || {wb_data_o, wb_rd_o, wb_we_o, wb_err_o} !== e) begin
            bad++;
            $display("FAIL lb_wb[%0d]: got %h required %h timeout=%0d/%0d",
                     u, {wb_data_o, wb_rd_o, wb_we_o, wb_err_o}, e, to, wto);
         end
         step();
      end
   endtask

   task automatic test_load_half();
      exp_t e;
      int   rc;
      bit   to;
      bit   wto;
      for (int u = 0; u < 2; u++) begin
         exp_q.push_back('{(u == 0) ? 32'hFFFF_8001 : 32'h0000_8001, 5'd12, 1'b1, 1'b0});
         // read and write both set must behave as a load
         issue(32'h0000_0402, 32'h5555_5555, 5'd12, 1'b1, 1'b1, 1'b1, 2'b01, u[0]);
         total++;
         if ({data_we_o, data_be_o} !== {1'b0, 4'b1100}) begin
            bad++;
            $display("FAIL lh_req[%0d]: we=%b be=%b required 0/1100", u, data_we_o, data_be_o);
         end
         serve(0, 1'b1, 1, 32'h8001_1234, rc, to);
         wait_wb(wto);
         e = exp_q.pop_front();
         total++;
         if (to || wto || {wb_data_o, wb_rd_o, wb_we_o, wb_err_o} !== e) begin
            bad++;
            $display("FAIL lh_wb[%0d]: got %h required %h", u, {wb_data_o, wb_rd_o, wb_we_o, wb_err_o}, e);
         end
         step();
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] addr_t [3] = '{32'h0000_0301, 32'h0000_0102, 32'h0000_0400};
      logic [1:0]  size_t [3] = '{2'b01, 2'b10, 2'b11};
      logic        wr_t   [3] = '{1'b0, 1'b1, 1'b0};
      exp_t        e;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{addr_t[i], 5'd6, 1'b0, 1'b1});
         issue(addr_t[i], 32'hFFFF_FFFF, 5'd6, 1'b1, ~wr_t[i], wr_t[i], size_t[i], 1'b0);
         e = exp_q.pop_front();
         total++;
         if (data_req_o !== 1'b0 || wb_valid_o !== 1'b1 ||
             {wb_data_o, wb_rd_o, wb_we_o, wb_err_o} !== e) begin
            bad++;
            $display("FAIL misaligned[%0d]: req=%b wb_valid=%b wb=%h required 0/1/%h",
                     i, data_req_o, wb_valid_o, {wb_data_o, wb_rd_o, wb_we_o, wb_err_o}, e);
         end
         step();
      end
   endtask

   task automatic test_load_word_stray();
      exp_t e;
      int   rc;
      bit   to;
      bit   wto;
      exp_q.push_back('{32'hCAFE_BABE, 5'd3, 1'b1, 1'b0});
      issue(32'h0000_0400, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      serve(2, 1'b1, 3, 32'hCAFE_BABE, rc, to);
      wait_wb(wto);
      e = exp_q.pop_front();
      total++;
      if (to || wto || rc != 3 || {wb_data_o, wb_rd_o, wb_we_o, wb_err_o} !== e) begin
         bad++;
         $display("FAIL lw_wb: got %h required %h req_cycles=%0d (required 3)",
                  {wb_data_o, wb_rd_o, wb_we_o, wb_err_o}, e, rc);
      end
      step();
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'h1111_1111;
      step();
      data_rvalid_i = 1'b0;
      total++;
      if (wb_valid_o !== 1'b0 || data_req_o !== 1'b0 || ready_o !== 1'b1) begin
         bad++;
         $display("FAIL stray_rvalid: wb_valid=%b req=%b ready=%b required 0/0/1", wb_valid_o, data_req_o, ready_o);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   rc;
      bit   to;
      bit   wto;
      ex_data_i   = 32'hA0A0_0001;
      rd_addr_i   = 5'd1;
      reg_write_i = 1'b1;
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      valid_i     = 1'b1;
      step();
      total++;
      if (wb_valid_o !== 1'b1 || wb_data_o !== 32'hA0A0_0001 || wb_rd_o !== 5'd1) begin
         bad++;
         $display("FAIL b2b_first: valid=%b data=%h rd=%0d required 1/a0a00001/1", wb_valid_o, wb_data_o, wb_rd_o);
      end
      ex_data_i   = 32'hB0B0_0002;
      rd_addr_i   = 5'd2;
      reg_write_i = 1'b0;
      step();
      valid_i = 1'b0;
      total++;
      if ({wb_valid_o, wb_data_o, wb_rd_o, wb_we_o} !== {1'b1, 32'hB0B0_0002, 5'd2, 1'b0}) begin
         bad++;
         $display("FAIL b2b_second: valid=%b data=%h rd=%0d we=%b required 1/b0b00002/2/0",
                  wb_valid_o, wb_data_o, wb_rd_o, wb_we_o);
      end
      exp_q.push_back('{32'h1122_3344, 5'd14, 1'b1, 1'b0});
      issue(32'h0000_0404, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      serve(0, 1'b1, 1, 32'h1122_3344, rc, to);
      wait_wb(wto);
      e = exp_q.pop_front();
      total++;
      if (to || wto || ready_o !== 1'b1 || {wb_data_o, wb_rd_o, wb_we_o, wb_err_o} !== e) begin
         bad++;
         $display("FAIL b2b_load: ready=%b got %h required 1/%h", ready_o, {wb_data_o, wb_rd_o, wb_we_o, wb_err_o}, e);
      end
      issue(32'hC0C0_0003, 32'h0, 5'd15, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
      total++;
      if ({wb_valid_o, wb_data_o, wb_rd_o} !== {1'b1, 32'hC0C0_0003, 5'd15}) begin
         bad++;
         $display("FAIL b2b_after_load: valid=%b data=%h rd=%0d required 1/c0c00003/15", wb_valid_o, wb_data_o, wb_rd_o);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int rc;
      bit to;
      issue(32'h0000_0408, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      serve(1, 1'b0, 0, 32'h0, rc, to);
      total++;
      if (to || ready_o !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_waiting: timeout=%0d ready=%b required 0/0", to, ready_o);
      end
      rst_i = 1'b1;
      #1;
      total++;
      if (data_req_o !== 1'b0 || ready_o !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_async: req=%b ready=%b required 0/1", data_req_o, ready_o);
      end
      step();
      rst_i = 1'b0;
      step();
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'hDEAD_BEEF;
      step();
      data_rvalid_i = 1'b0;
      total++;
      if (wb_valid_o !== 1'b0 || ready_o !== 1'b1) begin
         bad++;
         $display("FAIL rst_mid_late_rvalid: wb_valid=%b ready=%b required 0/1", wb_valid_o, ready_o);
      end
      step();
   endtask

   initial begin
      rst_i          = 1'b1;
      valid_i        = 1'b0;
      ex_data_i      = '0;
      rdata2_store_i = '0;
      mem_read_i     = 1'b0;
      mem_write_i    = 1'b0;
      mem_size_i     = 2'b00;
      mem_unsigned_i = 1'b0;
      rd_addr_i      = '0;
      reg_write_i    = 1'b0;
      data_gnt_i     = 1'b0;
      data_rvalid_i  = 1'b0;
      data_rdata_i   = '0;
      test_reset();
      test_alu();
      test_store_byte();
      test_store_half();
      test_load_byte();
      test_load_half();
      test_misaligned();
      test_load_word_stray();
      test_back_to_back();
      test_reset_mid();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
